// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the IF-stage controller (master) and pc_unit (slave).
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic            pc_write_i;
  logic            mem_stall_i;
  logic            branch_taken_i;
  logic [XLEN-1:0] branch_target_i;
  logic            trap_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_next_o;
  logic            valid_o;
  logic            flush_o;
  logic            pending_o;
  logic            misalign_o;

  modport master (
    output start_i, pc_write_i, mem_stall_i, branch_taken_i, branch_target_i, trap_i,
    input  pc_o, pc_next_o, valid_o, flush_o, pending_o, misalign_o
  );

  modport slave (
    input  start_i, pc_write_i, mem_stall_i, branch_taken_i, branch_target_i, trap_i,
    output pc_o, pc_next_o, valid_o, flush_o, pending_o, misalign_o
  );
endinterface

// File: rtl/pc_unit.sv
// IF-stage program counter with IDLE/RUN control, trap-over-branch redirect priority,
// a one-entry pending-redirect buffer for stalls and a registered IF/ID flush pulse.
module pc_unit #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]      TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned          INSTR_BYTES  = 4
) (
  input logic      clk_i,
  input logic      rst_n_i,
  pc_unit_if.slave bus
);
  localparam int unsigned ALIGN_BITS = $clog2(INSTR_BYTES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic            r_flush;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_target;
  logic            w_advance;
  logic            w_redirect;
  logic [XLEN-1:0] w_pc_next;

  assign w_advance = bus.pc_write_i & ~bus.mem_stall_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i)  w_state_next = S_RUN;
      S_RUN:   if (!bus.start_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.valid_o = (r_state == S_RUN);
  end

  always_comb begin
    w_redirect = 1'b0;
    w_pc_next  = RESET_VECTOR;
    if (r_state == S_RUN) begin
      w_redirect = bus.trap_i | r_pend_valid | bus.branch_taken_i;
      if (bus.trap_i)              w_pc_next = TRAP_VECTOR;
      else if (r_pend_valid)       w_pc_next = r_pend_target;
      else if (bus.branch_taken_i) w_pc_next = bus.branch_target_i;
      else                         w_pc_next = r_pc + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc          <= RESET_VECTOR;
      r_flush       <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (r_state == S_IDLE || !bus.start_i) begin
      r_pc         <= RESET_VECTOR;
      r_flush      <= 1'b0;
      r_pend_valid <= 1'b0;
    end else if (w_advance) begin
      r_pc         <= w_pc_next;
      r_flush      <= w_redirect;
      r_pend_valid <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      // A trap always replaces the buffer; a branch only fills an empty one.
      if (bus.trap_i) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= TRAP_VECTOR;
      end else if (bus.branch_taken_i && !r_pend_valid) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= bus.branch_target_i;
      end
    end
  end

  assign bus.pc_o      = r_pc;
  assign bus.pc_next_o = w_pc_next;
  assign bus.flush_o   = r_flush;
  assign bus.pending_o = r_pend_valid;

  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign bus.misalign_o = 1'b0;
    end else begin : g_align
      assign bus.misalign_o = |r_pc[ALIGN_BITS-1:0];
    end
  endgenerate
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: default 32-bit instance driven from a vector table,
// plus an 8-bit/2-byte instance for wrap-around and misalignment.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(32)) bus ();
  pc_unit_if #(.XLEN(8))  bus8 ();

  pc_unit dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  pc_unit #(
    .XLEN(8), .RESET_VECTOR(8'hFC), .TRAP_VECTOR(8'h10), .INSTR_BYTES(2)
  ) dut8 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus8));

  typedef struct {
    logic        st, pw, ms, br, tr;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_v, e_f, e_p;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        v, f, p;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic st, logic pw, logic ms, logic br, logic [31:0] tgt,
                              logic tr, logic [31:0] e_pc, logic e_v, logic e_f, logic e_p);
    vec_t v;
    v.st = st; v.pw = pw; v.ms = ms; v.br = br; v.tgt = tgt; v.tr = tr;
    v.e_pc = e_pc; v.e_v = e_v; v.e_f = e_f; v.e_p = e_p;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    bus.start_i = v.st; bus.pc_write_i = v.pw; bus.mem_stall_i = v.ms;
    bus.branch_taken_i = v.br; bus.branch_target_i = v.tgt; bus.trap_i = v.tr;
    #1;
    if (v.pw && !v.ms) check($sformatf("pc_next[%0d]", idx), bus.pc_next_o, v.e_pc);
    e.pc = v.e_pc; e.v = v.e_v; e.f = v.e_f; e.p = v.e_p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("pc[%0d]", idx),      bus.pc_o, e.pc);
    check($sformatf("valid[%0d]", idx),   {31'd0, bus.valid_o}, {31'd0, e.v});
    check($sformatf("flush[%0d]", idx),   {31'd0, bus.flush_o}, {31'd0, e.f});
    check($sformatf("pending[%0d]", idx), {31'd0, bus.pending_o}, {31'd0, e.p});
    check($sformatf("misalign[%0d]", idx), {31'd0, bus.misalign_o}, 32'd0);
  endtask

  task automatic step8(input logic br, input logic [7:0] tgt, input logic tr,
                       input logic [7:0] e_pc, input logic e_f, input logic e_mis, input string name);
    @(negedge clk);
    bus8.start_i = 1'b1; bus8.pc_write_i = 1'b1; bus8.mem_stall_i = 1'b0;
    bus8.branch_taken_i = br; bus8.branch_target_i = tgt; bus8.trap_i = tr;
    @(posedge clk);
    #1;
    check({name, "_pc"},    {24'd0, bus8.pc_o}, {24'd0, e_pc});
    check({name, "_flush"}, {31'd0, bus8.flush_o}, {31'd0, e_f});
    check({name, "_mis"},   {31'd0, bus8.misalign_o}, {31'd0, e_mis});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start_i = 0; bus.pc_write_i = 0; bus.mem_stall_i = 0;
    bus.branch_taken_i = 0; bus.branch_target_i = '0; bus.trap_i = 0;
    bus8.start_i = 0; bus8.pc_write_i = 0; bus8.mem_stall_i = 0;
    bus8.branch_taken_i = 0; bus8.branch_target_i = '0; bus8.trap_i = 0;
    #12;
    check("rst_pc",    bus.pc_o, 32'h0);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_flush", {31'd0, bus.flush_o}, 32'd0);
    check("rst_pend",  {31'd0, bus.pending_o}, 32'd0);
    check("rst8_pc",   {24'd0, bus8.pc_o}, 32'hFC);
    @(negedge clk);
    rst_n = 1'b1;

    //            st pw ms br tgt        tr  pc         v  f  p
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h4,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h8,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'hC,   1, 0, 0));
    for (int unsigned a = 32'h10; a <= 32'h20; a += 4)
      vecs.push_back(mk(1, 1, 0, 0, 32'h0, 0, a, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h80,  0, 32'h80,  1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h84,  1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h40,  0, 32'h84,  1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,   0, 32'h84,  1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,   0, 32'h84,  1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h40,  1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h44,  1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h40,  0, 32'h44,  1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,   1, 32'h44,  1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 32'h200, 0, 32'h44,  1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h100, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h104, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h300, 0, 32'h104, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 32'h500, 0, 32'h300, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h600, 1, 32'h100, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h700, 0, 32'h100, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   1, 32'h100, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h104, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h40,  0, 32'h104, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h80,  1, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h80,  0, 32'h0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h4,   1, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset while a redirect sits in the buffer.
    @(negedge clk);
    bus.mem_stall_i = 1'b1; bus.branch_taken_i = 1'b1; bus.branch_target_i = 32'h40;
    @(posedge clk);
    #1;
    check("stall_pend", {31'd0, bus.pending_o}, 32'd1);
    check("stall_pc",   bus.pc_o, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",    bus.pc_o, 32'h0);
    check("arst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("arst_pend",  {31'd0, bus.pending_o}, 32'd0);
    check("arst_flush", {31'd0, bus.flush_o}, 32'd0);
    bus.start_i = 0; bus.mem_stall_i = 0; bus.branch_taken_i = 0;
    @(negedge clk);
    rst_n = 1'b1;

    step8(0, 8'h00, 0, 8'hFC, 0, 0, "w8_start");
    check("w8_valid", {31'd0, bus8.valid_o}, 32'd1);
    step8(0, 8'h00, 0, 8'hFE, 0, 0, "w8_fe");
    step8(0, 8'h00, 0, 8'h00, 0, 0, "w8_wrap");
    step8(1, 8'h03, 0, 8'h03, 1, 1, "w8_br03");
    step8(0, 8'h00, 0, 8'h05, 0, 1, "w8_seq05");
    step8(1, 8'h40, 1, 8'h10, 1, 0, "w8_trap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
